// File: rtl/hdmi_timing_pkg.sv
//----------------------------------------------------------------------
// hdmi_timing_pkg : shared types and 720p defaults for the raster timing
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package hdmi_timing_pkg;

  localparam int COORD_W   = 12;
  localparam int MAX_TOTAL = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  function automatic coord_t to_coord(input int value);
    return coord_t'(value);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hdmi_timing_axis.sv
//----------------------------------------------------------------------
// hdmi_timing_axis : one raster axis (counter + ACTIVE/FP/SYNC/BP phase FSM)
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module hdmi_timing_axis
  import hdmi_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adv,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap,
  output logic               active,
  output logic               sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  if (ACTIVE <= 0 || FP <= 0 || SYNC <= 0 || BP <= 0) begin : g_bad_phase
    $error("hdmi_timing_axis: every phase length must be non-zero");
  end
  if (TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("hdmi_timing_axis: axis total exceeds counter range");
  end

  localparam coord_t END_ACTIVE = to_coord(ACTIVE - 1);
  localparam coord_t END_FP     = to_coord(ACTIVE + FP - 1);
  localparam coord_t END_SYNC   = to_coord(ACTIVE + FP + SYNC - 1);
  localparam coord_t END_TOTAL  = to_coord(TOTAL - 1);

  phase_t phase;
  coord_t phase_end;

  always_comb begin
    phase_end = END_TOTAL;
    case (phase)
      PH_ACTIVE: phase_end = END_ACTIVE;
      PH_FP:     phase_end = END_FP;
      PH_SYNC:   phase_end = END_SYNC;
      default:   phase_end = END_TOTAL;
    endcase
  end

  assign wrap   = adv && (cnt == END_TOTAL);
  assign active = (phase == PH_ACTIVE);
  assign sync   = (phase == PH_SYNC);

  // The BP phase ends on the last count, so the phase FSM and counter wrap together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= PH_ACTIVE;
    end else if (adv) begin
      cnt <= wrap ? '0 : cnt + coord_t'(1);
      if (cnt == phase_end) begin
        case (phase)
          PH_ACTIVE: phase <= PH_FP;
          PH_FP:     phase <= PH_SYNC;
          PH_SYNC:   phase <= PH_BP;
          default:   phase <= PH_ACTIVE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hdmi_video_timing.sv
//----------------------------------------------------------------------
// hdmi_video_timing : HDMI raster timing generator (coords, DE, syncs, strobes)
// Option macro HDMI_TIMING_SYNC_DELAY_EN delays syncs/strobes 1 clk, adds de_out.
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module hdmi_video_timing
  import hdmi_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic               data_en,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
`ifdef HDMI_TIMING_SYNC_DELAY_EN
  ,
  output logic               de_out
`endif
);

  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_wrap;
  logic   v_wrap_unused;
  logic   h_active;
  logic   v_active;
  logic   h_sync;
  logic   v_sync;
  logic   de_next;

  hdmi_timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .adv    (1'b1),
    .cnt    (h_cnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  hdmi_timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .adv    (h_wrap),
    .cnt    (v_cnt),
    .wrap   (v_wrap_unused),
    .active (v_active),
    .sync   (v_sync)
  );

  assign de_next = h_active && v_active;

  logic hs_s1;
  logic vs_s1;
  logic ls_s1;
  logic fs_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      px_x    <= '0;
      px_y    <= '0;
      data_en <= 1'b0;
      hs_s1   <= ~HS_POL;
      vs_s1   <= ~VS_POL;
      ls_s1   <= 1'b0;
      fs_s1   <= 1'b0;
    end else begin
      px_x    <= de_next ? h_cnt : '0;
      px_y    <= de_next ? v_cnt : '0;
      data_en <= de_next;
      hs_s1   <= h_sync ? HS_POL : ~HS_POL;
      vs_s1   <= v_sync ? VS_POL : ~VS_POL;
      ls_s1   <= de_next && (h_cnt == '0);
      fs_s1   <= de_next && (h_cnt == '0) && (v_cnt == '0);
    end
  end

`ifdef HDMI_TIMING_SYNC_DELAY_EN
  // Extra stage lines syncs/strobes up with the colour stage's registered pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      de_out      <= 1'b0;
    end else begin
      hsync       <= hs_s1;
      vsync       <= vs_s1;
      line_start  <= ls_s1;
      frame_start <= fs_s1;
      de_out      <= data_en;
    end
  end
`else
  assign hsync       = hs_s1;
  assign vsync       = vs_s1;
  assign line_start  = ls_s1;
  assign frame_start = fs_s1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hdmi_video_timing.sv
//----------------------------------------------------------------------
// tb_hdmi_video_timing : directed bench, small raster H 8/2/2/2, V 4/1/1/1
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_hdmi_video_timing;

  localparam int HT = 14;
  localparam int FT = 98;
`ifdef HDMI_TIMING_SYNC_DELAY_EN
  localparam int SD = 1;
`else
  localparam int SD = 0;
`endif

  typedef logic [28:0] bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] px_x, px_y, px_x_n, px_y_n;
  logic        data_en, hsync, vsync, line_start, frame_start;
  logic        data_en_n, hsync_n, vsync_n, line_start_n, frame_start_n;
`ifdef HDMI_TIMING_SYNC_DELAY_EN
  logic        de_out, de_out_n;
`endif

  int tests = 0;
  int fails = 0;
  int p     = -1;

  always #5 clk = ~clk;

  hdmi_video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .px_x(px_x), .px_y(px_y), .data_en(data_en),
    .hsync(hsync), .vsync(vsync), .line_start(line_start), .frame_start(frame_start)
`ifdef HDMI_TIMING_SYNC_DELAY_EN
    , .de_out(de_out)
`endif
  );

  hdmi_video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .clk(clk), .rst(rst), .px_x(px_x_n), .px_y(px_y_n), .data_en(data_en_n),
    .hsync(hsync_n), .vsync(vsync_n), .line_start(line_start_n), .frame_start(frame_start_n)
`ifdef HDMI_TIMING_SYNC_DELAY_EN
    , .de_out(de_out_n)
`endif
  );

  // p counts output cycles since reset release; p<0 means reset values.
  function automatic logic e_de(input int q);
    if (q < 0) return 1'b0;
    return ((q % HT) < 8) && (((q / HT) % 7) < 4);
  endfunction

  function automatic logic e_hs(input int q, input bit pol);
    if (q < 0) return ~pol;
    return (((q % HT) == 10) || ((q % HT) == 11)) ? pol : ~pol;
  endfunction

  function automatic logic e_vs(input int q, input bit pol);
    if (q < 0) return ~pol;
    return (((q / HT) % 7) == 5) ? pol : ~pol;
  endfunction

  function automatic logic e_ls(input int q);
    return e_de(q) && ((q % HT) == 0);
  endfunction

  function automatic logic e_fs(input int q);
    return (q >= 0) && ((q % FT) == 0);
  endfunction

  function automatic bundle_t exp_bundle(input int q, input bit pol);
    logic [11:0] ex, ey;
    ex = e_de(q) ? 12'(q % HT) : 12'd0;
    ey = e_de(q) ? 12'((q / HT) % 7) : 12'd0;
    return {ex, ey, e_de(q), e_hs(q - SD, pol), e_vs(q - SD, pol), e_ls(q - SD), e_fs(q - SD)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    p++;
  endtask

  task automatic run_to(input int target);
    while (p < target) tick();
  endtask

  task automatic test_reset();
    bundle_t got, want;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    p = -1;
    got  = {px_x, px_y, data_en, hsync, vsync, line_start, frame_start};
    want = exp_bundle(-1, 1'b1);
    tests++;
    if (got !== want) begin
      fails++; $display("FAIL reset_outputs got %h want %h", got, want);
    end
    tests++;
    if ({hsync_n, vsync_n} !== 2'b11) begin
      fails++; $display("FAIL reset_pol0_sync_idle got %b want 11", {hsync_n, vsync_n});
    end
    tick();
    tests++;
    if ({data_en, px_x, px_y} !== {1'b1, 24'd0}) begin
      fails++; $display("FAIL first_pixel got de=%b x=%0d y=%0d want de=1 x=0 y=0", data_en, px_x, px_y);
    end
    tests++;
    if (frame_start !== (SD == 0)) begin
      fails++; $display("FAIL first_frame_start got %b want %b", frame_start, (SD == 0));
    end
  endtask

  task automatic test_line_scan();
    bundle_t got, want;
    int de_cnt = 0, hs_cnt = 0, ls_first = -1, ls_second = -1;
    for (int i = 0; i < 2 * HT; i++) begin
      got  = {px_x, px_y, data_en, hsync, vsync, line_start, frame_start};
      want = exp_bundle(p, 1'b1);
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL line_scan p=%0d got %h want %h", p, got, want);
      end
      got  = {px_x_n, px_y_n, data_en_n, hsync_n, vsync_n, line_start_n, frame_start_n};
      want = exp_bundle(p, 1'b0);
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL line_scan_pol0 p=%0d got %h want %h", p, got, want);
      end
`ifdef HDMI_TIMING_SYNC_DELAY_EN
      tests++;
      if (de_out !== e_de(p - 1)) begin
        fails++; $display("FAIL de_out p=%0d got %b want %b", p, de_out, e_de(p - 1));
      end
`endif
      if (p < HT && data_en) de_cnt++;
      if (hsync) hs_cnt++;
      if (line_start) begin
        if (ls_first < 0) ls_first = p;
        else if (ls_second < 0) ls_second = p;
      end
      tick();
    end
    tests++;
    if (de_cnt !== 8) begin
      fails++; $display("FAIL line_de_count got %0d want 8", de_cnt);
    end
    tests++;
    if (hs_cnt !== 4) begin
      fails++; $display("FAIL line_hsync_count got %0d want 4", hs_cnt);
    end
    tests++;
    if (ls_second - ls_first !== HT) begin
      fails++; $display("FAIL line_start_period got %0d want %0d", ls_second - ls_first, HT);
    end
  endtask

  task automatic test_frame_scan();
    bundle_t got, want;
    int vs_cnt = 0, de_cnt = 0, fs_cnt = 0, fs_at = -1;
    run_to(FT);
    for (int i = 0; i < FT; i++) begin
      got  = {px_x, px_y, data_en, hsync, vsync, line_start, frame_start};
      want = exp_bundle(p, 1'b1);
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL frame_scan p=%0d got %h want %h", p, got, want);
      end
      got  = {px_x_n, px_y_n, data_en_n, hsync_n, vsync_n, line_start_n, frame_start_n};
      want = exp_bundle(p, 1'b0);
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL frame_scan_pol0 p=%0d got %h want %h", p, got, want);
      end
      if (vsync) vs_cnt++;
      if (data_en) de_cnt++;
      if (frame_start) begin
        fs_cnt++;
        fs_at = p;
      end
      tick();
    end
    tests++;
    if (vs_cnt !== HT) begin
      fails++; $display("FAIL frame_vsync_clks got %0d want %0d", vs_cnt, HT);
    end
    tests++;
    if (de_cnt !== 32) begin
      fails++; $display("FAIL frame_de_count got %0d want 32", de_cnt);
    end
    tests++;
    if (fs_cnt !== 1 || fs_at !== FT + SD) begin
      fails++; $display("FAIL frame_start_once got count=%0d at=%0d want count=1 at=%0d", fs_cnt, fs_at, FT + SD);
    end
    run_to(2 * FT + SD);
    tests++;
    if (frame_start !== 1'b1) begin
      fails++; $display("FAIL frame_start_period got %b at p=%0d want 1", frame_start, p);
    end
  endtask

  task automatic test_wrap();
    bundle_t got, want;
    run_to(3 * FT - 1);
    for (int i = 0; i < 3; i++) begin
      got  = {px_x, px_y, data_en, hsync, vsync, line_start, frame_start};
      want = exp_bundle(p, 1'b1);
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL wrap p=%0d got %h want %h", p, got, want);
      end
      if (p == 3 * FT + SD) begin
        tests++;
        if (frame_start !== 1'b1) begin
          fails++; $display("FAIL wrap_frame_start got %b want 1", frame_start);
        end
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    bundle_t got, want;
    run_to(4 * FT + 2 * HT + 5);
    tests++;
    if ({data_en, px_x, px_y} !== {1'b1, 12'd5, 12'd2}) begin
      fails++; $display("FAIL mid_pre_reset got de=%b x=%0d y=%0d want de=1 x=5 y=2", data_en, px_x, px_y);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p = -1;
    for (int i = 0; i < 3; i++) begin
      got  = {px_x, px_y, data_en, hsync, vsync, line_start, frame_start};
      want = exp_bundle(p, 1'b1);
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL mid_reset p=%0d got %h want %h", p, got, want);
      end
      got  = {px_x_n, px_y_n, data_en_n, hsync_n, vsync_n, line_start_n, frame_start_n};
      want = exp_bundle(p, 1'b0);
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL mid_reset_pol0 p=%0d got %h want %h", p, got, want);
      end
      if (p == SD) begin
        tests++;
        if (frame_start !== 1'b1) begin
          fails++; $display("FAIL mid_restart_frame_start got %b want 1", frame_start);
        end
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at p=%0d", p);
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_line_scan();
    test_frame_scan();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
